// File: rtl/hs_rx_fifo_if.sv
// Handshake bundle for hs_rx_fifo: upstream valid/ready push side, downstream
// first-word-fall-through result side, plus occupancy and status observables.
interface hs_rx_fifo_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             ready_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [LVL_W-1:0] level;
  logic [7:0]       rx_cnt;
  logic             proto_err;

  modport master (
    output valid, data, ready_in,
    input  ready, result, result_valid, level, rx_cnt, proto_err
  );

  modport slave (
    input  valid, data, ready_in,
    output ready, result, result_valid, level, rx_cnt, proto_err
  );
endinterface

// File: rtl/hs_rx_fifo.sv
// Receive FIFO with first-word fall-through output, accepted-transfer counter
// and a sticky monitor for upstream valid/data hold-rule violations.
module hs_rx_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input logic         sys_clk,
  input logic         sys_rst_n,
  hs_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [7:0]       rx_cnt_q;
  logic             proto_err_q;

  logic             vld_p1;
  logic             ready_p1;
  logic [WIDTH-1:0] data_p1;

  logic not_full;
  logic not_empty;
  logic push;
  logic pop;
  logic hold_violation;

  // DEPTH is a power of two, so dropping the carry wraps the pointer.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return ptr + 1'b1;
  endfunction

  assign not_full  = (level_q < LW'(DEPTH));
  assign not_empty = (level_q != '0);

  // ready looks only at registered occupancy, never at ready_in.
  assign bus.ready = not_full && sys_rst_n;
  assign push      = bus.valid && bus.ready;
  assign pop       = not_empty && bus.ready_in;

  assign hold_violation = vld_p1 && !ready_p1 &&
                          (!bus.valid || (bus.data != data_p1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      rx_cnt_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        rx_cnt_q <= rx_cnt_q + 8'd1;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (hold_violation) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // ---- stage p1: previous-cycle handshake snapshot for the hold check ----
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      vld_p1   <= 1'b0;
      ready_p1 <= 1'b0;
      data_p1  <= '0;
    end else begin
      vld_p1   <= bus.valid;
      ready_p1 <= bus.ready;
      data_p1  <= bus.data;
    end
  end

  // Storage is not reset; push is already blocked while reset is low.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data;
    end
  end

  assign bus.result       = not_empty ? mem[rd_ptr] : '0;
  assign bus.result_valid = not_empty;
  assign bus.level        = level_q;
  assign bus.rx_cnt       = rx_cnt_q;
  assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_hs_rx_fifo.sv
// Directed bench for hs_rx_fifo (WIDTH=3, DEPTH=4): reset, single transfer,
// fill/hold, drain order, streaming wrap, hold violation and counter wrap.
module tb_hs_rx_fifo;
  localparam int WIDTH = 3;
  localparam int DEPTH = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_asserts = 0;
  int   n_fail    = 0;
  bit   done      = 1'b0;

  logic [2:0] stream_d [10] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3,
                                3'd6, 3'd1, 3'd4, 3'd5, 3'd2};

  hs_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  hs_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: test did not complete within the wait limit");
      $finish;
    end
  end

  initial begin
    bus.valid    = 1'b0;
    bus.data     = '0;
    bus.ready_in = 1'b0;
    sys_rst_n    = 1'b0;
    #1;
    chk("ready_low_in_reset", bus.ready, 1'b0);
    tick();
    chk("ready_low_in_reset_edge", bus.ready, 1'b0);
    sys_rst_n = 1'b1;
    #1;
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_result_valid", bus.result_valid, 1'b0);
    chk("rst_result", bus.result, 3'd0);
    chk("rst_level", bus.level, 3'd0);
    chk("rst_rx_cnt", bus.rx_cnt, 8'd0);
    chk("rst_proto_err", bus.proto_err, 1'b0);

    // Empty buffer ignores ready_in
    bus.ready_in = 1'b1;
    tick();
    chk("empty_pop_level", bus.level, 3'd0);
    chk("empty_pop_rv", bus.result_valid, 1'b0);

    // Single transfer
    bus.valid = 1'b1;
    bus.data  = 3'd5;
    #1;
    chk("no_passthrough_rv", bus.result_valid, 1'b0);
    tick();
    bus.valid = 1'b0;
    chk("single_result", bus.result, 3'd5);
    chk("single_rv", bus.result_valid, 1'b1);
    chk("single_rx_cnt", bus.rx_cnt, 8'd1);
    chk("single_level", bus.level, 3'd1);
    tick();
    chk("single_rv_drop", bus.result_valid, 1'b0);
    chk("single_level_zero", bus.level, 3'd0);
    chk("single_result_zero", bus.result, 3'd0);

    // Fill to full, then hold valid while stalled
    bus.ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.valid = 1'b1;
      bus.data  = 3'(i);
      tick();
    end
    chk("full_level", bus.level, 3'd4);
    chk("full_ready", bus.ready, 1'b0);
    chk("full_head", bus.result, 3'd1);
    bus.data = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_level", bus.level, 3'd4);
      chk("full_hold_perr", bus.proto_err, 1'b0);
    end
    chk("full_hold_rx_cnt", bus.rx_cnt, 8'd5);

    // Drain in order; held word 6 enters once space opens
    bus.ready_in = 1'b1;
    tick();
    chk("drain_1_result", bus.result, 3'd2);
    chk("drain_1_level", bus.level, 3'd3);
    chk("drain_1_ready", bus.ready, 1'b1);
    tick();
    bus.valid = 1'b0;
    chk("drain_2_result", bus.result, 3'd3);
    chk("drain_2_level", bus.level, 3'd3);
    chk("drain_2_rx_cnt", bus.rx_cnt, 8'd6);
    tick();
    chk("drain_3_result", bus.result, 3'd4);
    chk("drain_3_level", bus.level, 3'd2);
    tick();
    chk("drain_4_result", bus.result, 3'd6);
    chk("drain_4_level", bus.level, 3'd1);
    tick();
    chk("drain_empty_rv", bus.result_valid, 1'b0);
    chk("drain_empty_level", bus.level, 3'd0);
    chk("drain_perr", bus.proto_err, 1'b0);

    // Simultaneous push/pop at level 2
    bus.ready_in = 1'b0;
    bus.valid    = 1'b1;
    bus.data     = 3'd7;
    tick();
    bus.data = 3'd1;
    tick();
    chk("sim_pre_level", bus.level, 3'd2);
    bus.ready_in = 1'b1;
    bus.data     = 3'd2;
    tick();
    bus.valid = 1'b0;
    chk("sim_level", bus.level, 3'd2);
    chk("sim_result", bus.result, 3'd1);
    tick();
    chk("sim_next_result", bus.result, 3'd2);
    chk("sim_next_level", bus.level, 3'd1);
    tick();
    chk("sim_empty_rv", bus.result_valid, 1'b0);

    // Clear rx_cnt, then stream 10 words at level 2 across two pointer wraps
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    #1;
    chk("stream_pre_rx_cnt", bus.rx_cnt, 8'd0);
    bus.ready_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.valid = 1'b1;
      bus.data  = stream_d[k];
      if (k == 2) bus.ready_in = 1'b1;
      tick();
      chk("stream_result", bus.result, stream_d[(k == 0) ? 0 : k - 1]);
      chk("stream_level", bus.level, (k == 0) ? 3'd1 : 3'd2);
    end
    bus.valid = 1'b0;
    tick();
    chk("stream_tail_result", bus.result, stream_d[9]);
    chk("stream_tail_level", bus.level, 3'd1);
    tick();
    chk("stream_empty_rv", bus.result_valid, 1'b0);
    chk("stream_rx_cnt", bus.rx_cnt, 8'd10);

    // Hold violation at full: data changes after a stall
    bus.ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.valid = 1'b1;
      bus.data  = 3'(i);
      tick();
    end
    bus.data = 3'd3;
    tick();
    chk("viol_pre_perr", bus.proto_err, 1'b0);
    bus.data = 3'd4;
    tick();
    chk("viol_perr_set", bus.proto_err, 1'b1);
    chk("viol_level", bus.level, 3'd4);
    bus.valid = 1'b0;
    tick();
    chk("viol_perr_sticky", bus.proto_err, 1'b1);
    chk("viol_rx_cnt", bus.rx_cnt, 8'd14);
    sys_rst_n = 1'b0;
    #1;
    chk("viol_rst_ready", bus.ready, 1'b0);
    tick();
    sys_rst_n = 1'b1;
    #1;
    chk("viol_rst_perr", bus.proto_err, 1'b0);
    chk("full_rst_level", bus.level, 3'd0);
    chk("full_rst_rv", bus.result_valid, 1'b0);
    chk("full_rst_ready", bus.ready, 1'b1);

    // Reset mid-stream at level 3
    bus.ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1;
      bus.data  = 3'(i + 5);
      tick();
    end
    bus.valid = 1'b0;
    chk("mid_pre_level", bus.level, 3'd3);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    #1;
    chk("mid_rst_level", bus.level, 3'd0);
    chk("mid_rst_rv", bus.result_valid, 1'b0);
    chk("mid_rst_ready", bus.ready, 1'b1);
    chk("mid_rst_result", bus.result, 3'd0);

    // 256 pushes wrap rx_cnt
    bus.ready_in = 1'b1;
    bus.valid    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.data = 3'(i);
      tick();
      if (i == 254) chk("cnt_255", bus.rx_cnt, 8'd255);
    end
    bus.valid = 1'b0;
    chk("cnt_wrap", bus.rx_cnt, 8'd0);
    chk("cnt_wrap_level", bus.level, 3'd1);
    chk("cnt_wrap_head", bus.result, 3'd7);
    tick();
    chk("cnt_final_level", bus.level, 3'd0);
    chk("cnt_final_perr", bus.proto_err, 1'b0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
